// File: rtl/regfile_wb_scheduler.sv
// Write-port scheduler for the 32x32 register file: scoreboard-based issue stall, ALU/memory
// writeback merge (ALU first) with a 2-entry memory FIFO, and $0 write protection.
module regfile_wb_scheduler #(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic [4:0]             issue_rs,
  input  logic [4:0]             issue_rt,
  input  logic [4:0]             issue_rd,
  input  logic                   issue_wr,
  output logic                   issue_stall,
  input  logic                   alu_wb_valid,
  input  logic [4:0]             alu_wb_addr,
  input  logic [31:0]            alu_wb_data,
  input  logic                   mem_wb_valid,
  input  logic [4:0]             mem_wb_addr,
  input  logic [31:0]            mem_wb_data,
  output logic                   mem_wb_ready,
  output logic                   rf_write,
  output logic [4:0]             rf_addrssw,
  output logic [31:0]            rf_write_material,
  output logic [31:0]            busy,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  logic [31:0]            busy_q, busy_d;
  logic [1:0]             fifo_cnt_q;
  logic                   fifo_rd_q, fifo_wr_q;
  logic [4:0]             fifo_addr_q [2];
  logic [31:0]            fifo_data_q [2];
  logic                   rf_write_q;
  logic [4:0]             rf_addr_q;
  logic [31:0]            rf_data_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  logic        fifo_push, fifo_pop, sel_valid;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  always_comb begin
    issue_stall  = issue_valid &
                   (busy_q[issue_rs] | busy_q[issue_rt] | (issue_wr & busy_q[issue_rd]));
    mem_wb_ready = (fifo_cnt_q != 2'd2);
    fifo_push    = mem_wb_valid & mem_wb_ready;
    fifo_pop     = ~alu_wb_valid & (fifo_cnt_q != 2'd0);
    sel_valid    = alu_wb_valid | (fifo_cnt_q != 2'd0);
    sel_addr     = alu_wb_valid ? alu_wb_addr : fifo_addr_q[fifo_rd_q];
    sel_data     = alu_wb_valid ? alu_wb_data : fifo_data_q[fifo_rd_q];

    // Clear first so that a same-cycle set on the same register wins.
    busy_d = busy_q;
    if (rf_write_q) busy_d[rf_addr_q] = 1'b0;
    if (issue_valid && !issue_stall && issue_wr && (issue_rd != 5'd0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q      <= '0;
      fifo_cnt_q  <= '0;
      fifo_rd_q   <= 1'b0;
      fifo_wr_q   <= 1'b0;
      rf_write_q  <= 1'b0;
      rf_addr_q   <= '0;
      rf_data_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
      if (fifo_push) begin
        fifo_addr_q[fifo_wr_q] <= mem_wb_addr;
        fifo_data_q[fifo_wr_q] <= mem_wb_data;
        fifo_wr_q              <= ~fifo_wr_q;
      end
      if (fifo_pop) fifo_rd_q <= ~fifo_rd_q;
      // A selected write to $0 still consumes its slot but never asserts the enable.
      rf_write_q <= sel_valid & (sel_addr != 5'd0);
      if (sel_valid) begin
        rf_addr_q <= sel_addr;
        rf_data_q <= sel_data;
      end
      if (issue_stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign rf_write          = rf_write_q;
  assign rf_addrssw        = rf_addr_q;
  assign rf_write_material = rf_data_q;
  assign busy              = busy_q;
  assign stall_cycles      = stall_cnt_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Randomized bench for regfile_wb_scheduler against a queue-based reference model,
// preceded by short directed sequences from the test plan.
module tb_regfile_wb_scheduler;

  localparam int unsigned W = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          issue_valid, issue_wr, issue_stall;
  logic [4:0]    issue_rs, issue_rt, issue_rd;
  logic          alu_wb_valid, mem_wb_valid, mem_wb_ready;
  logic [4:0]    alu_wb_addr, mem_wb_addr, rf_addrssw;
  logic [31:0]   alu_wb_data, mem_wb_data, rf_write_material, busy;
  logic          rf_write;
  logic [W-1:0]  stall_cycles;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(.STALL_CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_stall(issue_stall),
    .alu_wb_valid(alu_wb_valid), .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
    .mem_wb_valid(mem_wb_valid), .mem_wb_addr(mem_wb_addr), .mem_wb_data(mem_wb_data),
    .mem_wb_ready(mem_wb_ready), .rf_write(rf_write), .rf_addrssw(rf_addrssw),
    .rf_write_material(rf_write_material), .busy(busy), .stall_cycles(stall_cycles)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: outstanding-write set, memory queue, pending write-port value.
  bit          m_busy [32];
  logic [4:0]  mq_addr [$];
  logic [31:0] mq_data [$];
  bit          m_rfw;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int unsigned m_stall;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    mq_addr.delete();
    mq_data.delete();
    m_rfw   = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    m_stall = 0;
  endtask

  task automatic idle();
    issue_valid = 0; issue_wr = 0; issue_rs = 0; issue_rt = 0; issue_rd = 0;
    alu_wb_valid = 0; alu_wb_addr = 0; alu_wb_data = 0;
    mem_wb_valid = 0; mem_wb_addr = 0; mem_wb_data = 0;
  endtask

  // Compare at the falling edge, then advance the model over the coming rising edge.
  task automatic step();
    bit stall, ready, have;
    logic [4:0]  a;
    logic [31:0] d;
    @(negedge clk);
    stall = issue_valid && (m_busy[issue_rs] || m_busy[issue_rt] || (issue_wr && m_busy[issue_rd]));
    ready = mq_addr.size() < 2;
    check_eq("issue_stall", issue_stall, stall);
    check_eq("mem_wb_ready", mem_wb_ready, ready);
    check_eq("rf_write", rf_write, m_rfw);
    check_eq("rf_addrssw", rf_addrssw, m_addr);
    check_eq("rf_write_material", rf_write_material, m_data);
    check_eq("busy", busy, model_busy_vec());
    check_eq("stall_cycles", stall_cycles, m_stall);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_rfw) m_busy[m_addr] = 1'b0;
      if (issue_valid && !stall && issue_wr && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      have = 1'b0;
      if (alu_wb_valid) begin
        have = 1'b1; a = alu_wb_addr; d = alu_wb_data;
      end else if (mq_addr.size() > 0) begin
        have = 1'b1; a = mq_addr.pop_front(); d = mq_data.pop_front();
      end
      if (mem_wb_valid && ready) begin
        mq_addr.push_back(mem_wb_addr);
        mq_data.push_back(mem_wb_data);
      end
      m_rfw = have && (a != 0);
      if (have) begin
        m_addr = a; m_data = d;
      end
      if (stall && m_stall != (2 ** W) - 1) m_stall++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    model_reset();
    // Reset held for two cycles with traffic requested.
    rst_n = 1'b0; issue_valid = 1; issue_wr = 1; issue_rd = 5'd4; mem_wb_valid = 1;
    mem_wb_addr = 5'd6;
    @(posedge clk); #1;
    step();
    rst_n = 1'b1;
    idle();
    step();
    check_eq("reset_busy", busy, 32'h0);
    check_eq("reset_ready", mem_wb_ready, 1'b1);

    // RAW stall: rd=5 issued, dependents stall until the ALU write retires.
    issue_valid = 1; issue_wr = 1; issue_rd = 5;
    step();
    issue_wr = 0; issue_rd = 0; issue_rs = 5;
    step();
    alu_wb_valid = 1; alu_wb_addr = 5; alu_wb_data = 32'hDEADBEEF;
    step();
    alu_wb_valid = 0;
    step();
    step();
    check_eq("raw_stall_cycles", stall_cycles, 3);
    idle();
    step();

    // Port contention: ALU and memory both valid for three cycles.
    for (int i = 0; i < 3; i++) begin
      alu_wb_valid = 1; alu_wb_addr = 5'(10 + i); alu_wb_data = 32'hA000 + i;
      mem_wb_valid = 1; mem_wb_addr = 5'(7 + i); mem_wb_data = 32'hB000 + i;
      step();
    end
    idle();
    for (int i = 0; i < 3; i++) step();

    // $0 protection.
    alu_wb_valid = 1; alu_wb_addr = 0; alu_wb_data = 32'h1234;
    issue_valid = 1; issue_wr = 1; issue_rd = 0;
    step();
    idle();
    step();

    // Set/clear collision on reg 3.
    issue_valid = 1; issue_wr = 1; issue_rd = 3;
    step();
    issue_valid = 0;
    alu_wb_valid = 1; alu_wb_addr = 3; alu_wb_data = 32'h33;
    step();
    alu_wb_valid = 0; issue_valid = 1;
    step();
    step();
    idle();
    step();
    step();

    // Mid-operation reset with a full FIFO and outstanding writes.
    for (int r = 5; r <= 8; r++) begin
      issue_valid = (r != 6); issue_wr = 1; issue_rd = 5'(r);
      alu_wb_valid = 1; alu_wb_addr = 5'd20; alu_wb_data = 32'h20;
      mem_wb_valid = 1; mem_wb_addr = 5'(r + 10); mem_wb_data = 32'(r);
      step();
    end
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Randomized traffic over a small register window to force hazards.
    for (int n = 0; n < 3000; n++) begin
      rst_n        = ($urandom_range(99) != 0);
      issue_valid  = $urandom_range(1);
      issue_wr     = $urandom_range(3) != 0;
      issue_rs     = 5'($urandom_range(7));
      issue_rt     = 5'($urandom_range(7));
      issue_rd     = 5'($urandom_range(7));
      alu_wb_valid = $urandom_range(9) < 4;
      alu_wb_addr  = 5'($urandom_range(7));
      alu_wb_data  = $urandom;
      mem_wb_valid = $urandom_range(1);
      mem_wb_addr  = 5'($urandom_range(7));
      mem_wb_data  = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
